// File: rtl/universal_reg_pkg.sv
// Shared definitions for the universal register.
// Holds the 3-bit operation encodings carried on the mode port. The RTL and
// the testbench both import this package so that they use the same codes.
package universal_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;  // keep q and cout
    localparam logic [2:0] MODE_LOAD = 3'b001;  // q <= d
    localparam logic [2:0] MODE_SHL  = 3'b010;  // shift left, sin_lsb enters at bit 0
    localparam logic [2:0] MODE_SHR  = 3'b011;  // shift right, sin_msb enters at the MSB
    localparam logic [2:0] MODE_ROTL = 3'b100;  // rotate left
    localparam logic [2:0] MODE_ROTR = 3'b101;  // rotate right
    localparam logic [2:0] MODE_INC  = 3'b110;  // q <= q + 1, wraps modulo 2^WIDTH
    localparam logic [2:0] MODE_DEC  = 3'b111;  // q <= q - 1, wraps modulo 2^WIDTH

endpackage

// File: rtl/universal_reg_dff_cp.sv
// dff_cp: one register bit with synchronous reset, clear, preset and enable.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, loads RST_VAL
//   clr  - synchronous active-low clear (loads 0), beats pre
//   pre  - synchronous active-low preset (loads 1)
//   en   - active-high enable for loading d
//   d    - next-state data
//   q    - stored bit
//   qb   - complement of the stored bit
// Priority at each edge: rst, then clr, then pre, then en, else hold.
module dff_cp #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic pre,
    input  logic en,
    input  logic d,
    output logic q,
    output logic qb
);

    logic q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= RST_VAL;
        end else if (!clr) begin
            q_reg <= 1'b0;
        end else if (!pre) begin
            q_reg <= 1'b1;
        end else if (en) begin
            q_reg <= d;
        end
    end

    // qb is derived from the same flop, so q and qb can never be equal,
    // even when clr and pre are both asserted.
    assign q  = q_reg;
    assign qb = ~q_reg;

endmodule

// File: rtl/universal_reg.sv
// universal_reg: WIDTH-bit register supporting hold, parallel load, shift,
// rotate, increment and decrement, with a registered carry/shift-out bit.
// Ports:
//   clk              - rising-edge clock
//   rst              - synchronous active-high reset (q <= RESET_VAL, cout <= 0)
//   clr              - synchronous active-low clear (q <= 0, cout <= 0)
//   pre              - synchronous active-low preset (q <= all ones, cout <= 0)
//   en               - enables the operation selected by mode
//   mode[2:0]        - operation select (see universal_reg_pkg)
//   d[WIDTH-1:0]     - parallel load data
//   sin_lsb, sin_msb - serial inputs for shl and shr respectively
//   q, qb            - register value and its complement
//   cout             - carry/borrow/shifted-out bit of the last operation
//   zero             - high when q is all zeros (combinational from q)
// Every state bit, including cout, is a dff_cp slice; this module only
// computes the next-state values fed to the slices.
module universal_reg
    import universal_reg_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             pre,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             cout,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_next;
    logic             cout_next;
    logic             cout_b_unused;  // complement output of the cout slice

    // Next-state selection. Hold re-presents the current cout so the cout
    // slice can share the common enable with the data slices.
    always_comb begin
        q_next    = q;
        cout_next = cout;
        case (mode)
            MODE_HOLD: begin
                q_next    = q;
                cout_next = cout;
            end
            MODE_LOAD: begin
                q_next    = d;
                cout_next = 1'b0;
            end
            MODE_SHL: begin
                q_next    = {q[WIDTH-2:0], sin_lsb};
                cout_next = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next    = {sin_msb, q[WIDTH-1:1]};
                cout_next = q[0];
            end
            MODE_ROTL: begin
                q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
                cout_next = q[WIDTH-1];
            end
            MODE_ROTR: begin
                q_next    = {q[0], q[WIDTH-1:1]};
                cout_next = q[0];
            end
            MODE_INC: begin
                q_next    = q + ONE;
                cout_next = &q;        // carry out only when wrapping from all ones
            end
            MODE_DEC: begin
                q_next    = q - ONE;
                cout_next = ~|q;       // borrow only when wrapping from zero
            end
            default: begin
                q_next    = q;
                cout_next = cout;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            dff_cp #(
                .RST_VAL (RESET_VAL[gi])
            ) u_bit (
                .clk (clk),
                .rst (rst),
                .clr (clr),
                .pre (pre),
                .en  (en),
                .d   (q_next[gi]),
                .q   (q[gi]),
                .qb  (qb[gi])
            );
        end
    endgenerate

    // cout is cleared by clr or pre rather than set by pre, so its slice sees
    // the preset input tied inactive and clear asserted by either of them.
    dff_cp #(
        .RST_VAL (1'b0)
    ) u_cout (
        .clk (clk),
        .rst (rst),
        .clr (clr & pre),
        .pre (1'b1),
        .en  (en),
        .d   (cout_next),
        .q   (cout),
        .qb  (cout_b_unused)
    );

    assign zero = ~|q;

endmodule

// File: tb/tb_universal_reg.sv
// Testbench for universal_reg: a directed vector table (WIDTH=8,
// RESET_VAL=8'hA5) followed by a randomised run on both an 8-bit and a
// 2-bit instance checked against a behavioural model. Expected results are
// queued when stimulus is driven and compared just after the next edge.
module tb_universal_reg;
    import universal_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst, clr, pre, en, sin_lsb, sin_msb;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q8, qb8;
    logic       cout8, zero8;
    logic [1:0] q2, qb2;
    logic       cout2, zero2;

    always #5 clk = ~clk;

    universal_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .clk(clk), .rst(rst), .clr(clr), .pre(pre), .en(en), .mode(mode),
        .d(d), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
        .q(q8), .qb(qb8), .cout(cout8), .zero(zero8)
    );

    universal_reg #(.WIDTH(2), .RESET_VAL(2'b10)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .pre(pre), .en(en), .mode(mode),
        .d(d[1:0]), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
        .q(q2), .qb(qb2), .cout(cout2), .zero(zero2)
    );

    typedef struct {
        logic       rst, clr, pre, en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sl, sm;
        logic [7:0] eq;
        logic       ec;
    } vec_t;

    typedef struct {
        int         tag;
        logic [7:0] q;
        logic       c;
        logic       chk2;
        logic [1:0] q2;
        logic       c2;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural reference for a w-bit register (w <= 8 here).
    function automatic void model(input int w, input logic [31:0] rv,
                                  input logic r, input logic cl, input logic pr,
                                  input logic e, input logic [2:0] m,
                                  input logic [31:0] dd, input logic sl, input logic sm,
                                  inout logic [31:0] mq, inout logic mc);
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        if (r) begin
            mq = rv & mask; mc = 1'b0;
        end else if (!cl) begin
            mq = 32'h0; mc = 1'b0;
        end else if (!pr) begin
            mq = mask; mc = 1'b0;
        end else if (e) begin
            case (m)
                MODE_LOAD: begin mq = dd & mask; mc = 1'b0; end
                MODE_SHL:  begin mc = mq[w-1]; mq = ((mq << 1) | 32'(sl)) & mask; end
                MODE_SHR:  begin mc = mq[0];   mq = (mq >> 1) | (32'(sm) << (w-1)); end
                MODE_ROTL: begin mc = mq[w-1]; mq = ((mq << 1) | 32'(mq[w-1])) & mask; end
                MODE_ROTR: begin mc = mq[0];   mq = (mq >> 1) | (32'(mq[0]) << (w-1)); end
                MODE_INC:  begin mc = (mq == mask);  mq = (mq + 32'h1) & mask; end
                MODE_DEC:  begin mc = (mq == 32'h0); mq = (mq - 32'h1) & mask; end
                default:   begin end
            endcase
        end
    endfunction

    task automatic drive(input logic r, input logic cl, input logic pr, input logic e,
                         input logic [2:0] m, input logic [7:0] dd,
                         input logic sl, input logic sm);
        rst = r; clr = cl; pre = pr; en = e; mode = m; d = dd;
        sin_lsb = sl; sin_msb = sm;
    endtask

    // Pop one expectation after the edge and compare every output.
    task automatic check_edge();
        exp_t e;
        @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: no expectation queued (got q=%h)", q8);
            return;
        end
        e = exp_q.pop_front();
        if (q8 !== e.q) begin
            miscompares++;
            $display("FAIL v%0d q: got %h expected %h", e.tag, q8, e.q);
        end
        if (qb8 !== ~e.q) begin
            miscompares++;
            $display("FAIL v%0d qb: got %h expected %h", e.tag, qb8, ~e.q);
        end
        if (cout8 !== e.c) begin
            miscompares++;
            $display("FAIL v%0d cout: got %b expected %b", e.tag, cout8, e.c);
        end
        if (zero8 !== (e.q == 8'h00)) begin
            miscompares++;
            $display("FAIL v%0d zero: got %b expected %b", e.tag, zero8, (e.q == 8'h00));
        end
        if (e.chk2) begin
            if (q2 !== e.q2 || qb2 !== ~e.q2 || cout2 !== e.c2 || zero2 !== (e.q2 == 2'b00)) begin
                miscompares++;
                $display("FAIL v%0d w2: got q=%b qb=%b c=%b z=%b expected q=%b c=%b",
                         e.tag, q2, qb2, cout2, zero2, e.q2, e.c2);
            end
        end
    endtask

    vec_t tbl[24];

    initial begin
        exp_t        e;
        logic [31:0] m8, m2;
        logic        mc8, mc2;
        logic        r, cl, pr, en_r, sl, sm;
        logic [2:0]  m;
        logic [7:0]  dd;

        drive(1'b0, 1'b1, 1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);

        //          rst   clr   pre   en    mode       d      sl    sm    q      cout
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0}; // reset wins
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0}; // clear
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'hFF, 1'b0}; // preset
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0}; // clear beats preset
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_SHL,  8'h00, 1'b0, 1'b0, 8'h02, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_ROTR, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_ROTR, 8'h00, 1'b0, 1'b0, 8'h80, 1'b1}; // old q[0]=1 rotated out
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_SHR,  8'h00, 1'b0, 1'b1, 8'hC0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_ROTL, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_SHL,  8'h00, 1'b1, 1'b0, 8'h03, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_LOAD, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_INC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_INC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1}; // wrap up
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_DEC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1}; // wrap down
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, MODE_LOAD, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1}; // en=0 holds all
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_HOLD, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1}; // hold keeps cout
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_LOAD, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_INC,  8'h00, 1'b0, 1'b0, 8'h11, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b0, MODE_INC,  8'h00, 1'b0, 1'b0, 8'h11, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_INC,  8'h00, 1'b0, 1'b0, 8'h12, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 1'b1, 1'b1, MODE_INC,  8'h00, 1'b0, 1'b0, 8'hA5, 1'b0}; // mid-run reset
        tbl[22] = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_INC,  8'h00, 1'b0, 1'b0, 8'hA6, 1'b0};
        tbl[23] = '{1'b0, 1'b1, 1'b1, 1'b1, MODE_DEC,  8'h00, 1'b0, 1'b0, 8'hA5, 1'b0};

        // Directed table (8-bit instance only).
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].clr, tbl[i].pre, tbl[i].en, tbl[i].mode,
                  tbl[i].d, tbl[i].sl, tbl[i].sm);
            e = '{tag: i, q: tbl[i].eq, c: tbl[i].ec, chk2: 1'b0, q2: 2'b00, c2: 1'b0};
            exp_q.push_back(e);
            check_edge();
        end

        // Randomised run on both widths; the first edge resets both models.
        m8 = 32'h0; m2 = 32'h0; mc8 = 1'b0; mc2 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            r    = (i == 0) || ($urandom_range(31) == 0);
            cl   = ($urandom_range(7) != 0);
            pr   = ($urandom_range(7) != 0);
            en_r = ($urandom_range(3) != 0);
            m    = 3'($urandom_range(7));
            dd   = 8'($urandom);
            sl   = 1'($urandom);
            sm   = 1'($urandom);
            @(negedge clk);
            drive(r, cl, pr, en_r, m, dd, sl, sm);
            model(8, 32'hA5, r, cl, pr, en_r, m, 32'(dd), sl, sm, m8, mc8);
            model(2, 32'h2,  r, cl, pr, en_r, m, 32'(dd), sl, sm, m2, mc2);
            e = '{tag: 100 + i, q: m8[7:0], c: mc8, chk2: 1'b1, q2: m2[1:0], c2: mc2};
            exp_q.push_back(e);
            check_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
